// File: rtl/i2s_audio_out_pkg.sv
// Shared types and helpers for the I2S / left-justified audio serialiser.
package holosynth_audio_pkg;

  typedef enum logic {
    FMT_I2S = 1'b0,
    FMT_LJ  = 1'b1
  } fmt_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // True when slot bit k carries a sample bit for a given MSB offset and width.
  function automatic logic slot_bit(input int k, input int off, input int depth);
    return (k >= off) && (k < off + depth);
  endfunction

endpackage

// File: rtl/i2s_audio_out_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV cycles while run is high,
// and flags the cycle before each bclk edge.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bclk,
  output logic tick_rise,
  output logic tick_fall
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt_r;
  logic             bclk_r;
  logic             wrap_s;

  assign wrap_s    = run && (div_cnt_r == DIV_W'(BCLK_DIV - 1));
  assign tick_fall = wrap_s & bclk_r;
  assign tick_rise = wrap_s & ~bclk_r;
  assign bclk      = bclk_r;

  // Divider counter and bit clock; both park at zero whenever run drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
      bclk_r    <= 1'b0;
    end else if (!run) begin
      div_cnt_r <= '0;
      bclk_r    <= 1'b0;
    end else if (wrap_s) begin
      div_cnt_r <= '0;
      bclk_r    <= ~bclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_audio_out.sv
// Master-mode stereo serialiser: double-buffers one pending sample and shifts
// it out as I2S or left-justified with self-generated BCLK/LRCK.
module i2s_audio_out
  import holosynth_audio_pkg::*;
#(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_DIV      = 4,
  parameter int FORMAT        = 0
) (
  input  logic                     AUDIO_CLK,
  input  logic                     reset_data_n,
  input  logic                     enable,
  input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
  input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
  input  logic                     sample_stb,
  output logic                     frame_req,
  output logic                     sample_taken,
  output logic                     overrun,
  output logic [7:0]               underrun_cnt,
  output logic                     AUD_BCLK,
  output logic                     AUD_DACLRCK,
  output logic                     AUD_DACDAT
);

  localparam int BC_W  = $clog2(2 * SLOT_BITS);
  localparam int IDX_W = (AUD_BIT_DEPTH > 1) ? $clog2(AUD_BIT_DEPTH) : 1;
  localparam int OFF   = (FORMAT == int'(FMT_I2S)) ? 1 : 0;

  state_e                   state_r;
  logic [BC_W-1:0]          bit_cnt_r;
  logic [AUD_BIT_DEPTH-1:0] pend_l_r, pend_r_r;
  logic [AUD_BIT_DEPTH-1:0] frame_l_r, frame_r_r;
  logic                     pend_valid_r;
  logic [7:0]               underrun_cnt_r;
  logic                     frame_req_r, sample_taken_r, overrun_r;
  logic                     lrck_r, dacdat_r;

  logic                     run_s, tick_fall_s, tick_rise_unused_s, bclk_s;
  logic                     wrap_s, load_s;
  logic [AUD_BIT_DEPTH-1:0] ld_l_s, ld_r_s, word_s;
  logic [BC_W-1:0]          nxt_cnt_s, nxt_k_s;
  logic                     nxt_chan_s, nxt_bit_s;
  logic [IDX_W-1:0]         idx_s;

  assign run_s  = (state_r == RUN) && enable;
  assign wrap_s = tick_fall_s && (bit_cnt_r == BC_W'(2 * SLOT_BITS - 1));
  assign load_s = ((state_r == IDLE) && enable) || (run_s && wrap_s);

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk       (AUDIO_CLK),
    .rst_n     (reset_data_n),
    .run       (run_s),
    .bclk      (bclk_s),
    .tick_rise (tick_rise_unused_s),
    .tick_fall (tick_fall_s)
  );

  // Frame source priority: pending sample, then same-cycle bypass, else replay.
  always_comb begin
    ld_l_s = frame_l_r;
    ld_r_s = frame_r_r;
    if (pend_valid_r) begin
      ld_l_s = pend_l_r;
      ld_r_s = pend_r_r;
    end else if (sample_stb) begin
      ld_l_s = lsound_in;
      ld_r_s = rsound_in;
    end else begin
      ld_l_s = frame_l_r;
      ld_r_s = frame_r_r;
    end
  end

  // Serial bit for the slot position the counter moves to next; on a load the
  // freshly selected left word is used so LJ can present its MSB immediately.
  always_comb begin
    nxt_cnt_s  = '0;
    nxt_chan_s = 1'b0;
    nxt_k_s    = '0;
    word_s     = '0;
    idx_s      = '0;
    nxt_bit_s  = 1'b0;
    if (load_s) begin
      nxt_cnt_s = '0;
    end else begin
      nxt_cnt_s = bit_cnt_r + BC_W'(1);
    end
    nxt_chan_s = (nxt_cnt_s >= BC_W'(SLOT_BITS));
    if (nxt_chan_s) begin
      nxt_k_s = nxt_cnt_s - BC_W'(SLOT_BITS);
      word_s  = frame_r_r;
    end else begin
      nxt_k_s = nxt_cnt_s;
      word_s  = load_s ? ld_l_s : frame_l_r;
    end
    idx_s = IDX_W'(AUD_BIT_DEPTH - 1 - int'(nxt_k_s) + OFF);
    if (slot_bit(int'(nxt_k_s), OFF, AUD_BIT_DEPTH)) begin
      nxt_bit_s = word_s[idx_s];
    end else begin
      nxt_bit_s = 1'b0;
    end
  end

  // Control FSM, serial outputs, frame loading and pending-register handling.
  always_ff @(posedge AUDIO_CLK or negedge reset_data_n) begin
    if (!reset_data_n) begin
      state_r        <= IDLE;
      bit_cnt_r      <= '0;
      pend_l_r       <= '0;
      pend_r_r       <= '0;
      frame_l_r      <= '0;
      frame_r_r      <= '0;
      pend_valid_r   <= 1'b0;
      underrun_cnt_r <= 8'd0;
      frame_req_r    <= 1'b0;
      sample_taken_r <= 1'b0;
      overrun_r      <= 1'b0;
      lrck_r         <= 1'b0;
      dacdat_r       <= 1'b0;
    end else begin
      frame_req_r    <= 1'b0;
      sample_taken_r <= 1'b0;
      overrun_r      <= 1'b0;

      case (state_r)
        IDLE: begin
          bit_cnt_r <= '0;
          lrck_r    <= 1'b0;
          if (enable) begin
            state_r  <= RUN;
            dacdat_r <= nxt_bit_s;
          end else begin
            dacdat_r <= 1'b0;
          end
        end
        RUN: begin
          if (!enable) begin
            state_r   <= IDLE;
            bit_cnt_r <= '0;
            lrck_r    <= 1'b0;
            dacdat_r  <= 1'b0;
          end else if (tick_fall_s) begin
            bit_cnt_r   <= nxt_cnt_s;
            lrck_r      <= nxt_chan_s;
            dacdat_r    <= nxt_bit_s;
            frame_req_r <= (nxt_cnt_s == BC_W'(SLOT_BITS));
          end else begin
            bit_cnt_r <= bit_cnt_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= '0;
          lrck_r    <= 1'b0;
          dacdat_r  <= 1'b0;
        end
      endcase

      // A strobe coincident with a pending load refills pending without overrun.
      if (load_s) begin
        frame_l_r <= ld_l_s;
        frame_r_r <= ld_r_s;
        if (pend_valid_r) begin
          sample_taken_r <= 1'b1;
          if (sample_stb) begin
            pend_l_r     <= lsound_in;
            pend_r_r     <= rsound_in;
            pend_valid_r <= 1'b1;
          end else begin
            pend_valid_r <= 1'b0;
          end
        end else if (sample_stb) begin
          sample_taken_r <= 1'b1;
        end else if (underrun_cnt_r != 8'hFF) begin
          underrun_cnt_r <= underrun_cnt_r + 8'd1;
        end else begin
          underrun_cnt_r <= underrun_cnt_r;
        end
      end else if (sample_stb) begin
        pend_l_r     <= lsound_in;
        pend_r_r     <= rsound_in;
        pend_valid_r <= 1'b1;
        overrun_r    <= pend_valid_r;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  assign frame_req    = frame_req_r;
  assign sample_taken = sample_taken_r;
  assign overrun      = overrun_r;
  assign underrun_cnt = underrun_cnt_r;
  assign AUD_BCLK     = bclk_s;
  assign AUD_DACLRCK  = lrck_r;
  assign AUD_DACDAT   = dacdat_r;

endmodule

// File: tb/tb_i2s_audio_out.sv
// Directed bench for i2s_audio_out: an I2S and a left-justified instance share
// stimulus; a scoreboard of expected frames is checked bit by bit at BCLK rise.
module tb_i2s_audio_out;

  logic        clk = 1'b0;
  logic        rst_n, enable, sample_stb;
  logic [23:0] lsound, rsound;

  logic       fr0, st0, ov0, bclk0, lrck0, dat0;
  logic       fr1, st1, ov1, bclk1, lrck1, dat1;
  logic [7:0] uc0, uc1;

  int checks   = 0;
  int failures = 0;
  int t        = 0;
  int cyc      = 0;

  logic [47:0] exp_q[$];
  logic [47:0] cur_m     = 48'h0;
  int          rise_cnt  = 0;
  int          last_rise = -1;
  logic        prev_bclk = 1'b0;

  i2s_audio_out #(.AUD_BIT_DEPTH(24), .SLOT_BITS(32), .BCLK_DIV(4), .FORMAT(0)) dut0 (
    .AUDIO_CLK(clk), .reset_data_n(rst_n), .enable(enable),
    .lsound_in(lsound), .rsound_in(rsound), .sample_stb(sample_stb),
    .frame_req(fr0), .sample_taken(st0), .overrun(ov0), .underrun_cnt(uc0),
    .AUD_BCLK(bclk0), .AUD_DACLRCK(lrck0), .AUD_DACDAT(dat0));

  i2s_audio_out #(.AUD_BIT_DEPTH(24), .SLOT_BITS(32), .BCLK_DIV(4), .FORMAT(1)) dut1 (
    .AUDIO_CLK(clk), .reset_data_n(rst_n), .enable(enable),
    .lsound_in(lsound), .rsound_in(rsound), .sample_stb(sample_stb),
    .frame_req(fr1), .sample_taken(st1), .overrun(ov1), .underrun_cnt(uc1),
    .AUD_BCLK(bclk1), .AUD_DACLRCK(lrck1), .AUD_DACDAT(dat1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic exp_bit(input logic [23:0] w, input int s, input int off);
    if (s >= off && s < off + 24) return w[23 - (s - off)];
    else return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  task automatic strobe(input logic [23:0] l, input logic [23:0] r);
    lsound     = l;
    rsound     = r;
    sample_stb = 1'b1;
    step();
    sample_stb = 1'b0;
  endtask

  // Per-bit scoreboard: each BCLK rise is slot bit rise_cnt%64 of the current frame.
  always @(negedge clk) begin
    if (!rst_n || !enable) begin
      rise_cnt  = 0;
      last_rise = -1;
      prev_bclk = 1'b0;
    end else begin
      if (bclk0 === 1'b1 && prev_bclk === 1'b0) begin
        automatic int k = rise_cnt % 64;
        automatic int s = k % 32;
        automatic logic [23:0] w;
        if (k == 0 && exp_q.size() > 0) cur_m = exp_q.pop_front();
        w = (k >= 32) ? cur_m[23:0] : cur_m[47:24];
        check("lrck_i2s", {31'd0, lrck0}, (k >= 32) ? 32'd1 : 32'd0);
        check("lrck_lj", {31'd0, lrck1}, (k >= 32) ? 32'd1 : 32'd0);
        check("dat_i2s", {31'd0, dat0}, {31'd0, exp_bit(w, s, 1)});
        check("dat_lj", {31'd0, dat1}, {31'd0, exp_bit(w, s, 0)});
        check("bclk_lj", {31'd0, bclk1}, 32'd1);
        if (last_rise >= 0) check("bclk_period", 32'(cyc - last_rise), 32'd8);
        last_rise = cyc;
        rise_cnt++;
      end
      prev_bclk = bclk0;
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; sample_stb = 1'b0; lsound = 24'h0; rsound = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame_req", {31'd0, fr0}, 32'd0);
    check("rst_taken", {31'd0, st0}, 32'd0);
    check("rst_overrun", {31'd0, ov1}, 32'd0);
    check("rst_underrun", {24'd0, uc0}, 32'd0);
    check("rst_bclk", {31'd0, bclk0}, 32'd0);
    check("rst_lrck", {31'd0, lrck1}, 32'd0);
    check("rst_dat", {30'd0, dat0, dat1}, 32'd0);
    rst_n = 1'b1;
    step();

    // Enable with nothing supplied: zero frames replay and underruns count.
    enable = 1'b1; t = -1; step();
    check("t1_underrun_first", {24'd0, uc0}, 32'd1);
    check("t1_taken_first", {31'd0, st0}, 32'd0);
    run_to(255); check("t1_frame_req_pre", {31'd0, fr0}, 32'd0);
    step();      check("t1_frame_req", {30'd0, fr0, fr1}, 32'd3);
    step();      check("t1_frame_req_post", {31'd0, fr0}, 32'd0);
    run_to(511); check("t1_underrun_511", {24'd0, uc0}, 32'd1);
    step();      check("t1_underrun_512", {24'd0, uc1}, 32'd2);
    check("t1_taken_512", {31'd0, st0}, 32'd0);
    enable = 1'b0; step();
    check("t1_idle_out", {29'd0, bclk0, lrck0, dat0}, 32'd0);

    // Sample strobed while idle loads on RUN entry.
    strobe(24'h800001, 24'h7FFFFF); exp_q.push_back({24'h800001, 24'h7FFFFF});
    check("t2_idle_taken", {31'd0, st0}, 32'd0);
    check("t2_idle_overrun", {31'd0, ov0}, 32'd0);
    enable = 1'b1; t = -1; step();
    check("t2_taken_i2s", {31'd0, st0}, 32'd1);
    check("t2_taken_lj", {31'd0, st1}, 32'd1);
    check("t2_underrun", {24'd0, uc0}, 32'd2);
    check("t2_lj_msb_now", {31'd0, dat1}, 32'd1);
    check("t2_i2s_gap_now", {31'd0, dat0}, 32'd0);
    run_to(512);
    check("t2_replay_underrun", {24'd0, uc0}, 32'd3);
    check("t2_replay_taken", {31'd0, st0}, 32'd0);

    // Two strobes in one frame: one overrun, second sample wins.
    run_to(599);
    strobe(24'h123456, 24'h654321); check("t4_first_overrun", {31'd0, ov0}, 32'd0);
    strobe(24'hABCDEF, 24'h135790); check("t4_overrun", {30'd0, ov0, ov1}, 32'd3);
    exp_q.push_back({24'hABCDEF, 24'h135790});
    step(); check("t4_overrun_pulse", {31'd0, ov0}, 32'd0);
    run_to(1024);
    check("t4_taken", {31'd0, st0}, 32'd1);
    check("t4_underrun", {24'd0, uc0}, 32'd3);

    // Strobe exactly on a load with nothing pending takes the bypass path.
    run_to(1535);
    strobe(24'h0F0F0F, 24'hF0F0F0); exp_q.push_back({24'h0F0F0F, 24'hF0F0F0});
    check("t5_taken", {31'd0, st0}, 32'd1);
    check("t5_overrun", {31'd0, ov0}, 32'd0);
    check("t5_underrun", {24'd0, uc0}, 32'd3);
    run_to(2048);
    check("t5_no_pending_taken", {31'd0, st0}, 32'd0);
    check("t5_no_pending_underrun", {24'd0, uc0}, 32'd4);

    // Strobe coincident with a pending load: old one loads, new one waits.
    run_to(2099);
    strobe(24'h2468AC, 24'h13579B); exp_q.push_back({24'h2468AC, 24'h13579B});
    run_to(2559);
    strobe(24'h5A5A5A, 24'hFFFFFF); exp_q.push_back({24'h5A5A5A, 24'hFFFFFF});
    check("t45_taken", {31'd0, st0}, 32'd1);
    check("t45_overrun", {31'd0, ov0}, 32'd0);
    run_to(3072);
    check("t45_second_taken", {31'd0, st0}, 32'd1);
    check("t45_underrun", {24'd0, uc0}, 32'd4);

    // Disable mid-frame at bit 40, then restart with the retained pending sample.
    run_to(3099);
    strobe(24'hC00003, 24'h000000); exp_q.push_back({24'hC00003, 24'h000000});
    run_to(3392);
    check("t6_lrck_before", {30'd0, lrck0, lrck1}, 32'd3);
    check("t6_dat_before", {30'd0, dat0, dat1}, 32'd3);
    enable = 1'b0; step();
    check("t6_off_bclk", {30'd0, bclk0, bclk1}, 32'd0);
    check("t6_off_lrck", {30'd0, lrck0, lrck1}, 32'd0);
    check("t6_off_dat", {30'd0, dat0, dat1}, 32'd0);
    step(); step();
    enable = 1'b1; t = -1; step();
    check("t6_restart_taken", {31'd0, st0}, 32'd1);
    check("t6_restart_lrck", {31'd0, lrck0}, 32'd0);
    check("t6_restart_underrun", {24'd0, uc0}, 32'd4);
    check("t6_restart_lj_msb", {31'd0, dat1}, 32'd1);
    run_to(256); check("t6_frame_req", {31'd0, fr0}, 32'd1);
    run_to(600);
    check("t6_rise_count", 32'(rise_cnt), 32'd75);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_audio_out.md
Name: i2s_audio_out

Overview:
- Serialises the synthesizer's parallel stereo output (lsound/rsound, AUD_BIT_DEPTH bits, two's complement) into an I2S or left-justified stream for the codec DAC.
- Sits directly downstream of the synthesizer top-level and runs in the AUDIO_CLK domain.
- Generates BCLK and LRCK itself as master.
- Double-buffers one pending stereo sample and reports sample requests, underruns and overruns.

Parameters:
- AUD_BIT_DEPTH, 24, sample width per channel.
- SLOT_BITS, 32, BCLK periods per channel slot; must be >= AUD_BIT_DEPTH+1.
- BCLK_DIV, 4, AUDIO_CLK cycles per BCLK half-period; must be >= 2.
- FORMAT, 0, 0 = I2S (MSB one BCLK after LRCK edge), 1 = left-justified (MSB on LRCK edge).

Ports:
- AUDIO_CLK  in  1  sole clock.
- reset_data_n  in  1  asynchronous active-low reset.
- enable  in  1  run serialiser; low = idle.
- lsound_in  in  AUD_BIT_DEPTH  left sample.
- rsound_in  in  AUD_BIT_DEPTH  right sample.
- sample_stb  in  1  one-cycle strobe; captures lsound_in/rsound_in into the pending register.
- frame_req  out  1  one-cycle pulse at right-slot start; upstream should supply the next sample.
- sample_taken  out  1  one-cycle pulse when a frame loads from pending or bypass.
- overrun  out  1  one-cycle pulse when sample_stb overwrites a still-valid pending sample.
- underrun_cnt  out  8  saturating count of frames with no fresh sample.
- AUD_BCLK  out  1  bit clock.
- AUD_DACLRCK  out  1  word clock; 0 = left, 1 = right.
- AUD_DACDAT  out  1  serial data, MSB first.

Behaviour:
- Reset values:
  - All outputs 0; underrun_cnt = 0.
  - Pending register and shift registers 0; pend_valid = 0; state IDLE.
- States:
  - IDLE -> RUN when enable = 1.
  - RUN -> IDLE on the first cycle enable = 0, regardless of position. Outputs go to 0 the next cycle and counters clear. pend_valid and the pending data are retained.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 in RUN.
  - At wrap, AUD_BCLK toggles.
  - tick_fall = wrap while AUD_BCLK = 1; tick_rise = wrap while AUD_BCLK = 0.
- Bit counter:
  - bit_cnt runs 0..2*SLOT_BITS-1 and advances on tick_fall, wrapping to 0.
  - AUD_DACLRCK = (bit_cnt >= SLOT_BITS), registered and updated with bit_cnt.
- Data:
  - AUD_DACDAT updates only on tick_fall, so it is stable across the BCLK rising edge.
  - Let k = slot bit index and off = 1 for FORMAT 0, 0 for FORMAT 1.
  - For off <= k < off+AUD_BIT_DEPTH, output sample bit [AUD_BIT_DEPTH-1-(k-off)]; otherwise output 0.
- Frame load (on RUN entry and on each bit_cnt wrap 2*SLOT_BITS-1 -> 0):
  - If pend_valid: load the left/right shift registers, clear pend_valid, pulse sample_taken.
  - Else if sample_stb is high in the same cycle: load directly from lsound_in/rsound_in (bypass), pulse sample_taken.
  - Else: replay the previous frame and increment underrun_cnt, saturating at 255.
- Pending register:
  - sample_stb sets pend_valid and captures the inputs, except when consumed by the bypass above.
  - sample_stb while pend_valid = 1 and not loading: overwrite and pulse overrun.
  - sample_stb coincident with a load from a valid pending: load takes the old pending; the new sample becomes pending with pend_valid = 1 and no overrun.
- frame_req pulses one cycle on the tick_fall where bit_cnt becomes SLOT_BITS.
- Timing:
  - Frame period = 4*SLOT_BITS*BCLK_DIV AUDIO_CLK cycles (512 at defaults).
  - Latency from a frame load to the MSB on AUD_DACDAT: 0 BCLKs for FORMAT 1, 1 BCLK for FORMAT 0.
- Reset mid-frame: immediate return to reset values (asynchronous).

Decomposition:
- Package holosynth_audio_pkg:
  - fmt_e {FMT_I2S = 0, FMT_LJ = 1}.
  - state_e {IDLE, RUN}.
  - Function slot_bit(k, off) returning the bit-select validity.
- Sub-module i2s_bclk_gen: div_cnt, AUD_BCLK, tick_rise/tick_fall, cleared by a run input.

Test Plan:
1. Reset, then enable with no sample_stb -> all outputs 0 during reset; first frame replays zeros; underrun_cnt = 1 after the first load and 2 after 512 more cycles.
2. FORMAT 0, sample_stb with L = 0x800001, R = 0x7FFFFF before enable -> sample_taken on the RUN entry cycle.
   - Left slot: bit 0 = 0, bits 1..24 = 1000_0000_0000_0000_0000_0001, bits 25..31 = 0.
   - Right slot: bit 0 = 0, bits 1..24 = 0111...1.
   - LRCK high for bit_cnt 32..63; BCLK period 8 cycles.
3. FORMAT 1, same data -> MSB present in bit 0 of each slot; bits 24..31 = 0.
4. Two sample_stb pulses between frame loads -> one overrun pulse; the second sample is transmitted next frame; underrun_cnt unchanged.
5. sample_stb coincident with a frame load while pend_valid = 0 -> bypass load, sample_taken, no underrun increment, pend_valid stays 0.
6. Deassert enable at bit_cnt = 40, hold 3 cycles, re-enable -> outputs 0 one cycle later; pending retained; restart at bit_cnt = 0 with LRCK = 0; retained sample loads with sample_taken.
